i2s_sample_tx: RTL and testbench

I2S_SAMPLE_TX -- requirements
Module: i2s_sample_tx

---
 rtl/i2s_sample_tx_pkg.sv | 11 +
 rtl/i2s_sample_tx_en_reg.sv | 21 ++
 rtl/i2s_sample_tx.sv | 114 +++++++++++
 tb/tb_i2s_sample_tx.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_sample_tx_pkg.sv
// rtl/i2s_sample_tx_pkg.sv - shared audio constants: default sample width and FSM state encoding
package i2s_sample_tx_pkg;

  // Default bits per channel sample
  localparam int I2S_DEFAULT_WIDTH = 16;

  // Serializer FSM states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/i2s_sample_tx_en_reg.sv
// rtl/i2s_sample_tx_en_reg.sv - enabled register with synchronous active-high clear
module i2s_sample_tx_en_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d whenever en is high; clear on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/i2s_sample_tx.sv
// rtl/i2s_sample_tx.sv - I2S stereo sample serializer; optional sticky underflow flag under I2S_TX_UNDERFLOW_EN
module i2s_sample_tx
  import i2s_sample_tx_pkg::*;
#(
  parameter int WIDTH = I2S_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bclk_en,
  input  logic [WIDTH-1:0] l_data,
  input  logic [WIDTH-1:0] r_data,
  input  logic             valid,
  output logic             ready,
  output logic             sdata,
  output logic             lrclk
`ifdef I2S_TX_UNDERFLOW_EN
  ,
  output logic             underflow
`endif
);

  localparam int FW = 2 * WIDTH;
  localparam int CW = $clog2(FW);
  localparam logic [CW-1:0] LAST = CW'(FW - 1);
  localparam logic [CW-1:0] HALF = CW'(WIDTH);

  logic [0:0]    state;
  logic [CW-1:0] count;
  logic [CW-1:0] count_inc;
  logic [FW-1:0] shift;
  logic [FW-1:0] hold_data;
  logic          hold_full;
  logic          accept;
  logic          at_wrap;
  logic          load;
  logic          transfer;

  assign ready     = ~hold_full;
  assign accept    = valid && ready;
  assign count_inc = count + CW'(1);
  assign at_wrap   = (state == ST_RUN) && (count == LAST);
  // A frame boundary: first load out of IDLE, or the wrap tick in RUN
  assign load      = bclk_en && (((state == ST_IDLE) && hold_full) || at_wrap);
  assign transfer  = load && hold_full;

  // Holding register for the next stereo pair, left channel in the upper half
  i2s_sample_tx_en_reg #(
    .WIDTH(FW)
  ) u_hold (
    .clk  (clk),
    .reset(reset),
    .en   (accept),
    .d    ({l_data, r_data}),
    .q    (hold_data)
  );

  // Holding register occupancy; accept and transfer are mutually exclusive
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_full <= 1'b1;
    end else if (transfer) begin
      hold_full <= 1'b0;
    end
  end

  // Serializer: sdata lags the shift MSB by one tick, giving the I2S one-bit delay
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
      shift <= '0;
      sdata <= 1'b0;
      lrclk <= 1'b0;
    end else if (bclk_en) begin
      case (state)
        ST_IDLE: begin
          if (hold_full) begin
            shift <= hold_data;
            count <= '0;
            lrclk <= 1'b0;
            sdata <= 1'b0;
            state <= ST_RUN;
          end
        end
        default: begin
          sdata <= shift[FW-1];
          if (count == LAST) begin
            count <= '0;
            lrclk <= 1'b0;
            shift <= hold_full ? hold_data : '0;
          end else begin
            shift <= {shift[FW-2:0], 1'b0};
            count <= count_inc;
            lrclk <= (count_inc >= HALF);
          end
        end
      endcase
    end
  end

`ifdef I2S_TX_UNDERFLOW_EN
  // Sticky flag: a frame boundary found no pair waiting, so a silent frame goes out
  always_ff @(posedge clk) begin
    if (reset) begin
      underflow <= 1'b0;
    end else if (bclk_en && at_wrap && !hold_full) begin
      underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_sample_tx.sv
// tb/tb_i2s_sample_tx.sv - self-checking bench for i2s_sample_tx with a frame-level reference model
module tb_i2s_sample_tx;

  localparam int W    = 16;
  localparam int FW   = 2 * W;
  localparam int LOGN = 256;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         bclk_en = 1'b0;
  logic         valid = 1'b0;
  logic [W-1:0] l_data = '0;
  logic [W-1:0] r_data = '0;
  logic         ready;
  logic         sdata;
  logic         lrclk;
`ifdef I2S_TX_UNDERFLOW_EN
  logic         underflow;
`endif

  int total = 0;
  int bad   = 0;

  i2s_sample_tx #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .bclk_en(bclk_en),
    .l_data (l_data),
    .r_data (r_data),
    .valid  (valid),
    .ready  (ready),
    .sdata  (sdata),
    .lrclk  (lrclk)
`ifdef I2S_TX_UNDERFLOW_EN
    ,
    .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit-clock tick generator: fixed every 4th cycle or random
  int bmode = 0;
  int cyc   = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (bmode == 0) bclk_en = (cyc % 4 == 0);
      else            bclk_en = ($urandom_range(0, 2) == 0);
    end
  end

  // Reference model: frames are whole {L,R} words; tick n of a running stream
  // carries bit (n-1) of the concatenated frame sequence, lrclk = (n mod 2W) >= W
  logic [FW-1:0] m_pend[$];
  logic [FW-1:0] m_frames[$];
  bit            m_started = 0;
  int            m_n = 0;
  bit            m_uf = 0;
  bit            m_tick = 0;
  bit            rdy_pre;

  always @(posedge clk) begin
    m_tick = 0;
    if (reset) begin
      m_started = 0;
      m_n = 0;
      m_pend.delete();
      m_frames.delete();
      m_uf = 0;
    end else begin
      rdy_pre = (m_pend.size() == 0);
      if (bclk_en) begin
        m_tick = 1;
        if (!m_started) begin
          if (m_pend.size() != 0) begin
            m_started = 1;
            m_n = 0;
            m_frames.push_back(m_pend.pop_front());
          end
        end else begin
          m_n++;
          if (m_n % FW == 0) begin
            if (m_pend.size() != 0) begin
              m_frames.push_back(m_pend.pop_front());
            end else begin
              m_frames.push_back('0);
              m_uf = 1;
            end
          end
        end
      end
      if (valid && rdy_pre) m_pend.push_back({l_data, r_data});
    end
  end

  // Per-cycle comparison against the model, plus a tick log of DUT outputs
  bit            cmp_on = 0;
  logic          log_s[0:LOGN-1];
  logic          log_l[0:LOGN-1];
  int            rises = 0;
  logic          prev_ready = 1'b1;
  logic [FW-1:0] fr;
  logic          e_sd;
  logic          e_lr;
  int            fidx;
  int            bidx;

  always @(negedge clk) begin
    if (cmp_on) begin
      e_sd = 1'b0;
      e_lr = 1'b0;
      if (m_started) begin
        e_lr = ((m_n % FW) >= W);
        if (m_n != 0) begin
          fidx = (m_n - 1) / FW;
          bidx = FW - 1 - ((m_n - 1) % FW);
          fr = m_frames[fidx];
          e_sd = fr[bidx];
        end
      end
      check("model_sdata", {31'd0, sdata}, {31'd0, e_sd});
      check("model_lrclk", {31'd0, lrclk}, {31'd0, e_lr});
      check("model_ready", {31'd0, ready}, {31'd0, (m_pend.size() == 0)});
`ifdef I2S_TX_UNDERFLOW_EN
      check("model_underflow", {31'd0, underflow}, {31'd0, m_uf});
`endif
      if (m_tick && m_started && m_n < LOGN) begin
        log_s[m_n] = sdata;
        log_l[m_n] = lrclk;
      end
      if (ready && !prev_ready) rises++;
      prev_ready = ready;
    end
  end

  function automatic logic [W-1:0] s_word(input int first);
    logic [W-1:0] w;
    for (int i = 0; i < W; i++) w[W-1-i] = log_s[first+i];
    return w;
  endfunction

  function automatic logic [W-1:0] l_word(input int first);
    logic [W-1:0] w;
    for (int i = 0; i < W; i++) w[W-1-i] = log_l[first+i];
    return w;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_tick(input int target);
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (m_started && m_n >= target) begin
        @(negedge clk);
        return;
      end
    end
    check("wait_tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_pair(input logic [W-1:0] l, input logic [W-1:0] r);
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (ready) begin
        l_data = l;
        r_data = r;
        valid  = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        return;
      end
    end
    check("send_pair_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] rl;
  logic [W-1:0] rr;
  bit           found;

  initial begin
    do_reset();
    cmp_on = 1;

    // Reset state holds across 100 ticks with no valid
    for (int t = 0; t < 100; t++) begin
      repeat (4) @(negedge clk);
      check("rst_ready", {31'd0, ready}, 32'd1);
      check("rst_sdata", {31'd0, sdata}, 32'd0);
      check("rst_lrclk", {31'd0, lrclk}, 32'd0);
    end

    // Single frame followed by an underflow frame
    send_pair(16'hA5C3, 16'h0F01);
    wait_tick(31);
`ifdef I2S_TX_UNDERFLOW_EN
    check("uf_before_wrap", {31'd0, underflow}, 32'd0);
`endif
    wait_tick(64);
    check("single_load_bit", {31'd0, log_s[0]}, 32'd0);
    check("single_left",  {16'd0, s_word(1)},  32'h0000A5C3);
    check("single_right", {16'd0, s_word(17)}, 32'h00000F01);
    check("single_lr_a",  {16'd0, l_word(1)},  32'h00000001);
    check("single_lr_b",  {16'd0, l_word(17)}, 32'h0000FFFE);
    check("uflow_left",   {16'd0, s_word(33)}, 32'd0);
    check("uflow_right",  {16'd0, s_word(49)}, 32'd0);
    check("uflow_lr_a",   {16'd0, l_word(33)}, 32'h00000001);
    check("uflow_lr_b",   {16'd0, l_word(49)}, 32'h0000FFFE);
`ifdef I2S_TX_UNDERFLOW_EN
    check("uf_after_wrap", {31'd0, underflow}, 32'd1);
`endif

    // Back-to-back: three contiguous frames, ready pulsing once per frame
    do_reset();
    rises = 0;
    send_pair(16'h1234, 16'h8765);
    send_pair(16'hFFFF, 16'h0000);
    send_pair(16'h8001, 16'h7FFE);
    wait_tick(96);
    check("b2b_l0", {16'd0, s_word(1)},  32'h00001234);
    check("b2b_r0", {16'd0, s_word(17)}, 32'h00008765);
    check("b2b_l1", {16'd0, s_word(33)}, 32'h0000FFFF);
    check("b2b_r1", {16'd0, s_word(49)}, 32'h00000000);
    check("b2b_l2", {16'd0, s_word(65)}, 32'h00008001);
    check("b2b_r2", {16'd0, s_word(81)}, 32'h00007FFE);
    check("b2b_ready_rises", rises, 32'd3);

    // Accept on the same cycle as an empty-holding wrap
    do_reset();
    send_pair(16'h5A5A, 16'hC3C3);
    found = 0;
    for (int k = 0; k < 5000 && !found; k++) begin
      @(posedge clk);
      #2;
      if (m_started && m_n == 31 && bclk_en && ready) found = 1;
    end
    check("samecyc_found", {31'd0, found}, 32'd1);
    l_data = 16'h6E11;
    r_data = 16'h9002;
    valid  = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    wait_tick(96);
    check("samecyc_zero_l", {16'd0, s_word(33)}, 32'd0);
    check("samecyc_zero_r", {16'd0, s_word(49)}, 32'd0);
    check("samecyc_next_l", {16'd0, s_word(65)}, 32'h00006E11);
    check("samecyc_next_r", {16'd0, s_word(81)}, 32'h00009002);
`ifdef I2S_TX_UNDERFLOW_EN
    check("samecyc_uf", {31'd0, underflow}, 32'd1);
`endif

    // Mid-frame reset at tick 9 with a second pair waiting
    do_reset();
    send_pair(16'hFFFF, 16'hFFFF);
    send_pair(16'hEEEE, 16'hEEEE);
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (m_started && m_n >= 9) break;
    end
    reset = 1'b1;
    @(negedge clk);
    check("midrst_ready", {31'd0, ready}, 32'd1);
    check("midrst_sdata", {31'd0, sdata}, 32'd0);
    check("midrst_lrclk", {31'd0, lrclk}, 32'd0);
`ifdef I2S_TX_UNDERFLOW_EN
    check("midrst_uf", {31'd0, underflow}, 32'd0);
`endif
    reset = 1'b0;
    send_pair(16'h3C5A, 16'h00FF);
    wait_tick(33);
    check("midrst_new_l", {16'd0, s_word(1)},  32'h00003C5A);
    check("midrst_new_r", {16'd0, s_word(17)}, 32'h000000FF);

    // Randomized traffic with random tick spacing and gaps
    do_reset();
    bmode = 1;
    for (int p = 0; p < 60; p++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 150)) @(negedge clk);
      rl = W'($urandom);
      rr = W'($urandom);
      send_pair(rl, rr);
    end
    repeat (300) @(negedge clk);
    bmode = 0;

    cmp_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
